// File: rtl/infrarojo_pkg.sv
// Shared constants for the infrared line sensor front end: channel bit
// indices and the line-position codes seen by firmware.
package infrarojo_pkg;

  localparam int IR_W  = 5;
  localparam int IR_L  = 4;
  localparam int IR_LC = 3;
  localparam int IR_C  = 2;
  localparam int IR_RC = 1;
  localparam int IR_R  = 0;

  typedef enum logic [2:0] {
    POS_NONE      = 3'd0,
    POS_FAR_LEFT  = 3'd1,
    POS_LEFT      = 3'd2,
    POS_CENTER    = 3'd3,
    POS_RIGHT     = 3'd4,
    POS_FAR_RIGHT = 3'd5,
    POS_JUNCTION  = 3'd6,
    POS_INVALID   = 3'd7
  } pos_e;

  function automatic pos_e pos_encode(input logic [IR_W-1:0] s);
    pos_e p;
    case (s)
      5'b00000:                   p = POS_NONE;
      5'b10000, 5'b11000:         p = POS_FAR_LEFT;
      5'b01000, 5'b01100:         p = POS_LEFT;
      5'b00100, 5'b01110:         p = POS_CENTER;
      5'b00010, 5'b00110:         p = POS_RIGHT;
      5'b00001, 5'b00011:         p = POS_FAR_RIGHT;
      5'b11111, 5'b11110, 5'b01111,
      5'b11100, 5'b00111:         p = POS_JUNCTION;
      default:                    p = POS_INVALID;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/infrarojo_deb_ch.sv
// One sensor channel: 2-flop synchroniser followed by a tick-sampled
// debounce counter that accepts a new level after DEB_N agreeing ticks.
module infrarojo_deb_ch #(
  parameter int unsigned DEB_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic stable_o,
  output logic stable_nxt_o
);

  localparam int CW = $clog2(DEB_N + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick_i) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CW'(DEB_N)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;

endmodule

// File: rtl/infrarojo_filtro.sv
// Five-channel infrared sensor filter: shared sample tick, per-channel
// debounce, registered line-position code and a sticky change flag.
module infrarojo_filtro
  import infrarojo_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEB_N    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] ir_raw,
  output logic [IR_W-1:0] ir_stable,
  output logic [2:0]      ir_pos,
  output logic            evt,
  input  logic            evt_clr
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [IR_W-1:0] stable_w, stable_nxt_w;
  pos_e            pos_q, pos_d;
  logic            evt_q, evt_d;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  for (genvar i = 0; i < IR_W; i++) begin : g_ch
    infrarojo_deb_ch #(.DEB_N(DEB_N)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_i        (ir_raw[i]),
      .tick_i       (tick),
      .stable_o     (stable_w[i]),
      .stable_nxt_o (stable_nxt_w[i])
    );
  end

  // Position follows the next stable value so both update on the same edge;
  // a change on the clear edge keeps the flag set.
  always_comb begin
    pos_d = pos_encode(stable_nxt_w);
    evt_d = (stable_nxt_w != stable_w) | (evt_q & ~evt_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      pos_q      <= POS_NONE;
      evt_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pos_q      <= pos_d;
      evt_q      <= evt_d;
    end
  end

  assign ir_stable = stable_w;
  assign ir_pos    = pos_q;
  assign evt       = evt_q;

endmodule
